// File: rtl/aftab_dawu.sv
// Data adjustment write unit: serialises a 1..4 byte little-endian store onto a byte-wide memory port.
// Latency: one IDLE cycle, then a REQ cycle per byte with a one-cycle GAP between bytes, then a one-cycle DONE pulse.
// Backpressure: each REQ holds writeMem/addrOut/dataOut stable until memReady is sampled high.
//
// Ports:
//   clk, rst (async, active-low)
//   startDAWU, nBytes, addrIn, dataIn, checkMisalignedDAWU : store request from datapath/controller
//   memReady                                               : memory accepted the current byte
//   writeMem, addrOut, dataOut                             : byte write request to memory
//   storeMisalignedFlag, completeDAWU                      : status back to the controller
module aftab_dawu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startDAWU,
    input  logic [1:0]        nBytes,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              memReady,
    input  logic              checkMisalignedDAWU,
    output logic              storeMisalignedFlag,
    output logic              completeDAWU,
    output logic [7:0]        dataOut,
    output logic [ADDR_W-1:0] addrOut,
    output logic              writeMem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q,    state_d;
    logic [1:0]          cnt_q,      cnt_d;
    logic [1:0]          n_q,        n_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   data_q,     data_d;
    logic [ADDR_W-1:0]   addr_out_q, addr_out_d;
    logic [7:0]          data_out_q, data_out_d;

    // Alignment is judged on the live request inputs so the controller
    // sees the flag in the same cycle it raises startDAWU.
    assign storeMisalignedFlag = checkMisalignedDAWU &
                                 (((nBytes == 2'd1) & addrIn[0]) |
                                  ((nBytes >= 2'd2) & (addrIn[1:0] != 2'b00)));

    assign writeMem     = (state_q == REQ);
    assign completeDAWU = (state_q == DONE);
    assign addrOut      = addr_out_q;
    assign dataOut      = data_out_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        addr_d     = addr_q;
        data_d     = data_q;
        addr_out_d = addr_out_q;
        data_out_d = data_out_q;

        case (state_q)
            IDLE: begin
                if (startDAWU) begin
                    addr_d = addrIn;
                    data_d = dataIn;
                    n_d    = nBytes;
                    cnt_d  = 2'd0;
                    if (storeMisalignedFlag) begin
                        state_d = DONE;
                    end else begin
                        // Output registers are loaded on entry to REQ so the
                        // byte/address are valid for the whole request and
                        // retain their last value once the store ends.
                        state_d    = REQ;
                        addr_out_d = addrIn;
                        data_out_d = dataIn[7:0];
                    end
                end
            end
            REQ: begin
                if (memReady) begin
                    if (cnt_q == n_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 2'd1;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                state_d    = REQ;
                addr_out_d = addr_q + ADDR_W'(cnt_q);
                data_out_d = data_q[{cnt_q, 3'b000} +: 8];
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            n_q        <= 2'd0;
            addr_q     <= '0;
            data_q     <= '0;
            addr_out_q <= '0;
            data_out_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            addr_out_q <= addr_out_d;
            data_out_q <= data_out_d;
        end
    end

endmodule

// File: tb/tb_aftab_dawu.sv
module tb_aftab_dawu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        startDAWU = 1'b0;
    logic [1:0]  nBytes = 2'd0;
    logic [31:0] addrIn = 32'h0;
    logic [31:0] dataIn = 32'h0;
    logic        memReady = 1'b0;
    logic        checkMisalignedDAWU = 1'b0;
    logic        storeMisalignedFlag;
    logic        completeDAWU;
    logic [7:0]  dataOut;
    logic [31:0] addrOut;
    logic        writeMem;

    int n_cmp = 0;
    int n_err = 0;

    aftab_dawu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .startDAWU           (startDAWU),
        .nBytes              (nBytes),
        .addrIn              (addrIn),
        .dataIn              (dataIn),
        .memReady            (memReady),
        .checkMisalignedDAWU (checkMisalignedDAWU),
        .storeMisalignedFlag (storeMisalignedFlag),
        .completeDAWU        (completeDAWU),
        .dataOut             (dataOut),
        .addrOut             (addrOut),
        .writeMem            (writeMem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A store of size s bytes (3-byte stores occupy a word slot) is
    // misaligned when the address is not a multiple of that slot size.
    function automatic bit model_mis(input logic [31:0] a, input logic [1:0] n, input logic chk);
        int unsigned sz;
        sz = (n == 2'd0) ? 1 : (n == 2'd1) ? 2 : 4;
        return chk && ((a % sz) != 0);
    endfunction

    // Issues one store and follows it to completion. max_wait bounds the
    // random number of cycles memReady is held low per byte; hold keeps the
    // first byte waiting 10 cycles while startDAWU and the inputs churn.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] n,
                            input logic chk, input int max_wait, input bit hold);
        logic [31:0] exp_a[$];
        logic [7:0]  exp_d[$];
        bit mis, prev_acc, done;
        int idx, wait_cnt, cyc;

        mis = model_mis(a, n, chk);
        if (!mis) begin
            for (int k = 0; k <= int'(n); k++) begin
                exp_a.push_back(a + 32'(k));
                exp_d.push_back(d[8*k +: 8]);
            end
        end

        @(negedge clk);
        check("idle_writeMem", 32'(writeMem), 32'd0);
        check("idle_complete", 32'(completeDAWU), 32'd0);
        addrIn = a;
        dataIn = d;
        nBytes = n;
        checkMisalignedDAWU = chk;
        startDAWU = 1'b1;
        memReady = 1'($urandom_range(0, 1));
        #1;
        check("misaligned_flag", 32'(storeMisalignedFlag), 32'(mis));

        idx = 0;
        wait_cnt = hold ? 10 : $urandom_range(0, max_wait);
        prev_acc = 0;
        done = 0;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (prev_acc) idx++;
            if (hold && idx == 0) begin
                startDAWU = 1'b1;
                addrIn = $urandom;
                dataIn = $urandom;
                nBytes = 2'($urandom_range(0, 3));
            end else begin
                startDAWU = 1'b0;
            end
            if (completeDAWU) begin
                check("bytes_written", 32'(idx), 32'(exp_a.size()));
                check("done_writeMem", 32'(writeMem), 32'd0);
                if (mis) check("misaligned_latency", 32'(cyc), 32'd1);
                if (!mis && !hold && max_wait == 0) check("tied_ready_latency", 32'(cyc), 32'(2 * (int'(n) + 1)));
                done = 1;
                memReady = 1'b0;
            end else if (writeMem) begin
                check("gap_between_bytes", 32'(prev_acc), 32'd0);
                check("write_in_range", 32'(idx < exp_a.size()), 32'd1);
                if (idx < exp_a.size()) begin
                    check("addrOut", addrOut, exp_a[idx]);
                    check("dataOut", 32'(dataOut), 32'(exp_d[idx]));
                end
                if (wait_cnt == 0) begin
                    memReady = 1'b1;
                    prev_acc = 1;
                    wait_cnt = $urandom_range(0, max_wait);
                end else begin
                    wait_cnt--;
                    memReady = 1'b0;
                    prev_acc = 0;
                end
            end else begin
                prev_acc = 0;
                memReady = 1'($urandom_range(0, 1));
            end
        end
        check("store_completed", 32'(done), 32'd1);
        memReady = 1'b0;
        startDAWU = 1'b0;
        @(negedge clk);
        check("complete_one_cycle", 32'(completeDAWU), 32'd0);
        check("after_done_writeMem", 32'(writeMem), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b0;
        #1;
        check("rst_writeMem", 32'(writeMem), 32'd0);
        check("rst_complete", 32'(completeDAWU), 32'd0);
        check("rst_addrOut", addrOut, 32'h0);
        check("rst_dataOut", 32'(dataOut), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Aligned word, ready after a few cycles per byte
        do_store(32'd100, 32'h40000093, 2'd3, 1'b1, 3, 0);
        // Byte store with checking enabled
        do_store(32'd7, 32'hAABBCCDD, 2'd0, 1'b1, 2, 0);
        // Misaligned halfword, checked then unchecked
        do_store(32'd101, 32'h1234ABCD, 2'd1, 1'b1, 1, 0);
        do_store(32'd101, 32'h1234ABCD, 2'd1, 1'b0, 1, 0);
        // Misaligned three-byte and word
        do_store(32'd202, 32'h00C0FFEE, 2'd2, 1'b1, 1, 0);
        do_store(32'd203, 32'hDEADBEEF, 2'd3, 1'b1, 1, 0);
        // Long hold on the first byte with startDAWU raised mid-transfer
        do_store(32'd200, 32'h89ABCDEF, 2'd3, 1'b1, 1, 1);
        // Address wrap
        do_store(32'hFFFFFFFE, 32'h04030201, 2'd3, 1'b0, 0, 0);
        // Tied-high ready latency for word and byte
        do_store(32'h40, 32'h11223344, 2'd3, 1'b1, 0, 0);
        do_store(32'h43, 32'h55667788, 2'd0, 1'b1, 0, 0);

        // Reset in the middle of a word store
        @(negedge clk);
        addrIn = 32'h300;
        dataIn = 32'hA1B2C3D4;
        nBytes = 2'd3;
        checkMisalignedDAWU = 1'b1;
        startDAWU = 1'b1;
        @(negedge clk);
        startDAWU = 1'b0;
        check("mid_req1_writeMem", 32'(writeMem), 32'd1);
        check("mid_req1_addr", addrOut, 32'h300);
        memReady = 1'b1;
        @(negedge clk);
        memReady = 1'b0;
        check("mid_gap_writeMem", 32'(writeMem), 32'd0);
        @(negedge clk);
        check("mid_req2_writeMem", 32'(writeMem), 32'd1);
        check("mid_req2_data", 32'(dataOut), 32'hC3);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_writeMem", 32'(writeMem), 32'd0);
        check("mid_rst_complete", 32'(completeDAWU), 32'd0);
        check("mid_rst_addrOut", addrOut, 32'h0);
        check("mid_rst_dataOut", 32'(dataOut), 32'h0);
        memReady = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_writeMem", 32'(writeMem), 32'd0);
            check("post_rst_complete", 32'(completeDAWU), 32'd0);
        end
        memReady = 1'b0;

        // Randomised stores
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
            do_store(ra, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 4), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
